// File: rtl/operand_mux_pkg.sv
// operand_mux_pkg
// Shared definitions for the registered operand multiplexer stage:
//   - mode_e : operating mode of the stage (direct select or round-robin)
//   - rr_inc : wrap-around increment of a round-robin channel index
package operand_mux_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  // Next round-robin index after idx, wrapping from n-1 back to 0.
  // n need not be a power of two, so a plain modulo on the index width is not enough.
  function automatic int rr_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/operand_mux_stage_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter. The priority pointer lives in the parent.
// Ports:
//   req       in  NUM_IN : request vector, one bit per channel
//   rr_ptr    in  SEL_W  : channel with highest priority this cycle
//   grant     out NUM_IN : one-hot grant, or all zero when nothing requests
//   grant_idx out SEL_W  : encoded index of the granted channel (0 when no grant)
module rr_arbiter #(
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  rr_ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  int   cand;
  logic found;

  // Walk upward from rr_ptr with wrap-around and grant the first requester seen.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_IN;
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = SEL_W'(cand);
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_mux_stage.sv
// operand_mux_stage
// Selects one of NUM_IN source channels (direct index or round-robin) and latches
// the chosen word into a single output register with valid/ready flow control.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   mode       : 0 = direct select by sel, 1 = round-robin among in_valid
//   sel        : channel index used in direct mode (out-of-range never accepts)
//   in_valid   : per-channel data valid
//   in_data    : packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_ready   : per-channel accept, one-hot or zero
//   out_valid  : output register holds a word
//   out_data   : registered selected word
//   out_src    : index of the channel that supplied out_data
//   out_ready  : downstream accepts the word
module operand_mux_stage
  import operand_mux_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  input  logic                    out_ready
);

  logic [SEL_W-1:0]  rr_ptr;
  logic [NUM_IN-1:0] dir_grant;
  logic [NUM_IN-1:0] rr_grant;
  logic [SEL_W-1:0]  rr_idx;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              load_en;
  logic              transfer;
  logic [WIDTH-1:0]  sel_word;

  // Direct decode: an out-of-range sel matches no channel, so it simply never grants.
  always_comb begin
    dir_grant = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      dir_grant[i] = (int'(sel) == i) && in_valid[i];
    end
  end

  rr_arbiter #(.NUM_IN(NUM_IN)) u_rr_arbiter (
    .req       (in_valid),
    .rr_ptr    (rr_ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  assign grant     = (mode == MODE_RR) ? rr_grant : dir_grant;
  assign grant_idx = (mode == MODE_RR) ? rr_idx   : sel;

  // Accept when empty or being drained this cycle; rst forces in_ready low so
  // nothing upstream believes a word was taken while the stage is held in reset.
  assign load_en  = !out_valid || out_ready;
  assign in_ready = (load_en && !rst) ? grant : '0;
  assign transfer = |(in_ready & in_valid);

  // One-hot AND-OR mux keeps the data path free of a variable part-select.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        sel_word = sel_word | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // A load takes priority over a drain, giving back-to-back words with no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_word;
      out_src   <= grant_idx;
      if (mode == MODE_RR) begin
        rr_ptr <= SEL_W'(rr_inc(int'(grant_idx), NUM_IN));
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/operand_mux_stage.md
# operand_mux_stage

Parametrised, registered successor to the 16-bit 4-input operand multiplexer. It selects one of `NUM_IN` `WIDTH`-bit source channels and latches the selected word into a single output register with valid/ready flow control. It supports two modes: direct select by an index, and round-robin arbitration among requesting channels. It sits between the register-file read ports and the accumulator ALU operand input, where back-pressure from the ALU must stall operand delivery.

## Interface
Parameters:
- `WIDTH`, 16: data width of every channel.
- `NUM_IN`, 4: number of input channels, at least 2; need not be a power of two.
- `SEL_W`, localparam `$clog2(NUM_IN)`: width of the index signals.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `mode`  in  1: 0 is direct select, 1 is round-robin.
- `sel`  in  `SEL_W`: channel index, used in direct mode only.
- `in_valid`  in  `NUM_IN`: per-channel data-valid.
- `in_data`  in  `NUM_IN*WIDTH`: packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- `in_ready`  out  `NUM_IN`: per-channel accept, one-hot or all zero.
- `out_valid`  out  1: output register holds a word.
- `out_data`  out  `WIDTH`: registered selected word.
- `out_src`  out  `SEL_W`: index of the channel that supplied `out_data`.
- `out_ready`  in  1: downstream consumer accepts the word.

## Operation
- `load_en = !out_valid || out_ready`. The stage can accept a word when it is empty or is being drained in the same cycle.
- Direct mode:
  - `grant` is one-hot at `sel` when `sel < NUM_IN` and `in_valid[sel]` is high; otherwise `grant` is zero.
  - An out-of-range `sel` never accepts data and is not an error.
- Round-robin mode:
  - `grant` is the first channel with `in_valid` high, searching upward from `rr_ptr` and wrapping from `NUM_IN-1` to 0.
  - If no channel has `in_valid` high, `grant` is zero.
- `in_ready[i] = load_en && grant[i]`. A transfer on channel i occurs when `in_valid[i] && in_ready[i]`.
- On a transfer:
  - `out_data` is loaded with the granted channel's word.
  - `out_src` is loaded with the granted index.
  - `out_valid` is set to 1.
  - In round-robin mode only, `rr_ptr` is set to (granted index + 1) mod `NUM_IN`.
- When `out_ready` is high, `out_valid` is high and no transfer occurs, `out_valid` clears to 0. `out_data` and `out_src` hold their last values.
- When `out_valid` is high and `out_ready` is low:
  - The output register holds.
  - All `in_ready` bits are 0.
- `rr_ptr` is not modified in direct mode. Switching mode preserves `rr_ptr` and takes effect at the next combinational evaluation. A word already in the output register is unaffected by a mode switch.
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_src` = 0, `rr_ptr` = 0.
  - `in_ready` is therefore 0 while `rst` is high.
  - An assertion of `rst` mid-stream discards the held word.

## Timing
- Latency is 1 cycle: a word accepted at edge N appears on `out_data` with `out_valid` high after edge N.
- Throughput is 1 word per cycle when `out_ready` is held high.
- `in_ready` is combinational from `out_ready`, `out_valid`, `in_valid`, `mode`, `sel` and `rr_ptr`. There is no combinational path from `in_data` to any output.
- Simultaneous drain and load in the same cycle is a single register update with no bubble.
- `in_valid` may drop without a transfer. The block imposes no stability rule on inputs, but upstream producers must hold data until `in_ready` is high.

## Structure
- Shared package `operand_mux_pkg` holds:
  - `MODE_DIRECT = 1'b0` and `MODE_RR = 1'b1`.
  - A function for the wrap-around increment of the round-robin index.
- Sub-module `rr_arbiter`, parametrised by `NUM_IN`:
  - Inputs: request vector and `rr_ptr`.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; `rr_ptr` remains in the parent.
- The top level contains the direct-select decode, the mode mux between the two grant sources, and the output register.

## Test plan
- Reset then idle: hold `rst` high for 3 cycles, then release with all `in_valid` at 0. Required: `out_valid` = 0, `out_data` = 0, `out_src` = 0, `in_ready` = 0.
- Direct mode: `sel` = 2, channel 2 data = 0xBEEF, `in_valid` = 4'b0110, `out_ready` = 1. Required: `in_ready` = 4'b0100; next cycle `out_data` = 0xBEEF, `out_src` = 2. Then set `sel` = 0 with `in_valid[0]` = 0. Required: no transfer and `out_valid` falls to 0.
- Round-robin: `in_valid` = 4'b1111, channel data 0x1000+i, `out_ready` = 1 for 6 cycles. Required: `out_src` sequence is 0,1,2,3,0,1 with matching data.
- Round-robin skip and wrap: `rr_ptr` = 3 with `in_valid` = 4'b0101. Required: channel 0 is granted and `rr_ptr` becomes 1. Then `in_valid` = 4'b0100 grants channel 2.
- Back-pressure: hold `out_ready` = 0 for 4 cycles with `out_valid` = 1. Required: `out_data` is stable and `in_ready` = 0. Then assert `out_ready` for 1 cycle while channel 1 is valid. Required: drain and load occur in the same edge with `out_valid` staying 1.
- Reset mid-stream: assert `rst` asynchronously while `out_valid` = 1 and `rr_ptr` = 2. Required: `out_valid` = 0 immediately without waiting for an edge, and `rr_ptr` = 0 after release.
